mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage; issues load/store to data memory, forwards ALU results to write-back, tracks branch decision.
// Latency: 1 cycle for non-memory ops; 2+N cycles for memory ops (N = wait cycles before mem_ack), bounded by TIMEOUT.
// Backpressure: stall holds upstream registers while a memory op waits; drops the op and sets sticky mem_error on timeout.
module mem_stage #(
    parameter logic [3:0]  OP_LD   = 4'h8,
    parameter logic [3:0]  OP_ST   = 4'h9,
    parameter logic [3:0]  OP_BEQ  = 4'hA,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  opcode,
    input  logic        aluZERO,
    input  logic [15:0] aluRESULT,
    input  logic [15:0] dataRFOut2,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic [3:0]  wb_opcode,
    output logic [15:0] wb_data,
    output logic        branch_taken,
    output logic        mem_error
);

    // Last wait-counter value before the request is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_wb_valid;
    logic [3:0]  r_wb_opcode;
    logic [15:0] r_wb_data;
    logic        r_branch_taken;
    logic        r_mem_error;

    logic        w_is_mem;
    logic        w_beq;
    logic        w_stall;
    logic        w_issue;   // IDLE -> REQ with a new memory op
    logic        w_wait;    // REQ, still waiting for ack
    logic        w_done;    // REQ, ack received this cycle
    logic        w_tmo;     // REQ, wait budget exhausted without ack
    logic        w_pass;    // IDLE, non-memory op (or bubble) flows to WB

    assign w_is_mem = in_valid && ((opcode == OP_LD) || (opcode == OP_ST));
    assign w_beq    = in_valid && (opcode == OP_BEQ) && aluZERO;

    // Next-state and per-cycle event decode; ack beats timeout in the final wait cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_issue     = 1'b0;
        w_wait      = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_pass      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    w_stall     = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_pass = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    w_wait  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held so upstream is never frozen by a stale decode.
    assign stall = w_stall & reset;

    // State register and wait counter; counter saturates naturally because it only counts below CNT_LAST.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_cnt <= 8'd0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Memory request interface; address/data/we are captured once at issue and held stable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
        end else if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (opcode == OP_ST);
            r_mem_addr  <= aluRESULT;
            r_mem_wdata <= dataRFOut2;
        end else if (w_done || w_tmo) begin
            r_mem_req <= 1'b0;
        end
    end

    // MEM/WB register; every edge updates wb_valid, and branch_taken tracks it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wb_valid     <= 1'b0;
            r_wb_opcode    <= 4'h0;
            r_wb_data      <= 16'h0000;
            r_branch_taken <= 1'b0;
        end else if (w_pass) begin
            r_wb_valid     <= in_valid;
            r_wb_opcode    <= opcode;
            r_wb_data      <= aluRESULT;
            r_branch_taken <= w_beq;
        end else if (w_done) begin
            r_wb_valid     <= 1'b1;
            r_wb_opcode    <= opcode;
            r_wb_data      <= r_mem_we ? 16'h0000 : mem_rdata;
            r_branch_taken <= w_beq;
        end else begin
            r_wb_valid     <= 1'b0;
            r_branch_taken <= 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_error <= 1'b0;
        end else if (w_tmo) begin
            r_mem_error <= 1'b1;
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign wb_valid     = r_wb_valid;
    assign wb_opcode    = r_wb_opcode;
    assign wb_data      = r_wb_data;
    assign branch_taken = r_branch_taken;
    assign mem_error    = r_mem_error;

endmodule
